nib_to_word: RTL

Write-path counterpart of the ILA nibble transmitter. The block collects 4-bit packets arriving from the SPI slave, least-significant nibble first, and reassembles them into one configuration word of arbitrary width. It sits between the SPI slave and the ILA configuration registers (trigger pattern, mask, pre-trigger count). It flags incomplete or stalled transfers with a timeout, and optionally checks a trailing checksum nibble.

---
 rtl/nib_to_word.sv | 114 +++++++++++
 1 files changed

// File: rtl/nib_to_word.sv
// nib_to_word: reassembles LSB-first SPI nibbles into one word with idle timeout; define NIB_TO_WORD_CHECKSUM_EN for a trailing XOR checksum nibble
module nib_to_word #(
  parameter int word_width = 24,
  parameter int timeout_cycles = 1024
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_write_active,
  input  logic [3:0]            i_nib,
  input  logic                  i_nib_valid,
  output logic [word_width-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_err,
  output logic                  o_busy
);
  localparam int N = (word_width - 1) / 4 + 1;
  localparam int SW = 4 * N;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(timeout_cycles);
`ifdef NIB_TO_WORD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
  logic [3:0] xacc;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif
  state_t state;
  logic [SW-1:0] shift_reg, shifted;
  logic [CW-1:0] cnt;
  logic [TW-1:0] idle;
  logic accept, last, timeout_hit;
  // new nibble enters at the top so the first nibble ends up in [3:0]
  always_comb begin
    accept = i_nib_valid & i_write_active;
    last = cnt == CW'(N - 1);
    timeout_hit = idle == TW'(timeout_cycles - 1);
    shifted = SW'({i_nib, shift_reg} >> 4);
  end
  // collection state machine: abort beats accept beats timeout
  always_ff @(posedge i_clk_ILA) begin
    if (!i_reset) begin
      state <= IDLE;
      shift_reg <= '0;
      cnt <= '0;
      idle <= '0;
      o_word <= '0;
      o_word_valid <= 1'b0;
      o_err <= 1'b0;
      o_busy <= 1'b0;
`ifdef NIB_TO_WORD_CHECKSUM_EN
      xacc <= '0;
`endif
    end else begin
      o_word_valid <= 1'b0;
      o_err <= 1'b0;
      if (state != IDLE && !i_write_active) begin
        state <= IDLE;
        cnt <= '0;
        idle <= '0;
        o_busy <= 1'b0;
`ifdef NIB_TO_WORD_CHECKSUM_EN
        xacc <= '0;
`endif
      end else if (accept) begin
        idle <= '0;
`ifdef NIB_TO_WORD_CHECKSUM_EN
        if (state == CHECK) begin
          if (i_nib == xacc) begin
            o_word <= word_width'(shift_reg);
            o_word_valid <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
          state <= IDLE;
          cnt <= '0;
          o_busy <= 1'b0;
          xacc <= '0;
        end else begin
          shift_reg <= shifted;
          xacc <= xacc ^ i_nib;
          o_busy <= 1'b1;
          state <= last ? CHECK : COLLECT;
          cnt <= last ? '0 : cnt + 1'b1;
        end
`else
        shift_reg <= shifted;
        if (last) begin
          o_word <= word_width'(shifted);
          o_word_valid <= 1'b1;
          state <= IDLE;
          cnt <= '0;
          o_busy <= 1'b0;
        end else begin
          state <= COLLECT;
          cnt <= cnt + 1'b1;
          o_busy <= 1'b1;
        end
`endif
      end else if (state != IDLE) begin
        if (timeout_hit) begin
          o_err <= 1'b1;
          state <= IDLE;
          cnt <= '0;
          idle <= '0;
          o_busy <= 1'b0;
`ifdef NIB_TO_WORD_CHECKSUM_EN
          xacc <= '0;
`endif
        end else begin
          idle <= idle + 1'b1;
        end
      end
    end
  end
endmodule
